clkdiv_multi: RTL and testbench

- Parametrised multi-channel clock divider; successor to the fixed two-output divider.
- Each channel has a runtime-programmable half-period and produces a square wave plus an optional one-cycle tick.
- New divisors are applied glitch-free at the next toggle boundary.
- A common clear re-aligns all channels' phase.
- Sits at top level between the 50 MHz board clock and display/timer logic. Outputs are clock-enables/slow signals, never clocks for flops.

---
 rtl/clkdiv_pkg.sv | 32 +++
 rtl/clkdiv_channel.sv | 101 ++++++++++
 rtl/clkdiv_multi.sv | 50 +++++
 tb/tb_clkdiv_multi.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/clkdiv_pkg.sv
// Shared constants and types for the multi-channel clock divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package clkdiv_pkg;

    // Default counter/divisor width; 30 bits covers a 10 s half-period at 50 MHz.
    localparam int CNT_W_DEF = 30;

    // Board clock frequency in Hz.
    localparam int CLK_HZ = 50_000_000;

    // Half-periods, in clk_in cycles, for commonly used output rates.
    localparam int HALF_1HZ = CLK_HZ / 2;
    localparam int HALF_2HZ = CLK_HZ / 4;
    localparam int HALF_10S = CLK_HZ * 5;

    // Per-channel state at the default width. Each channel keeps the same
    // layout, sized to its own CNT_W.
    typedef struct packed {
        logic [CNT_W_DEF-1:0] counter;
        logic [CNT_W_DEF-1:0] half;
        logic [CNT_W_DEF-1:0] shadow;
        logic                 pend;
        logic                 out;
    } ch_state_t;

    // Width of a channel-select field; a single channel still needs one bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider slice: counter, active/shadow half-period, registered square wave and tick.
// Latency: outputs registered; a toggle appears H edges after the counter restarts.
// Backpressure: none; en=0 freezes the slice, writes land in the shadow at any time. Tick needs CLKDIV_TICK_EN.
module clkdiv_channel
    import clkdiv_pkg::*;
#(
    parameter int               CNT_W    = CNT_W_DEF,
    parameter logic [CNT_W-1:0] DIV_INIT = CNT_W'(HALF_1HZ)
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sync_clr,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_val,
    output logic             pend,
    output logic             clk_out,
    output logic             tick
);

    typedef struct packed {
        logic [CNT_W-1:0] counter;
        logic [CNT_W-1:0] half;
        logic [CNT_W-1:0] shadow;
        logic             pend;
        logic             out;
    } state_t;

    state_t           st;
    logic [CNT_W-1:0] last;
    logic             at_end;

    // Full-width terminal compare; a zero half never reaches the end of a half-period.
    assign last   = st.half - CNT_W'(1);
    assign at_end = (st.half != '0) && (st.counter == last);

    // Counter, toggle and shadow apply; a write is handled last so a same-cycle
    // write always survives as pending.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            st.counter <= '0;
            st.half    <= DIV_INIT;
            st.shadow  <= DIV_INIT;
            st.pend    <= 1'b0;
            st.out     <= 1'b0;
        end else begin
            if (sync_clr) begin
                // Shadow always holds the latest value, so copying it is a no-op when nothing is pending.
                st.counter <= '0;
                st.out     <= 1'b0;
                st.half    <= st.shadow;
                st.pend    <= 1'b0;
            end else if (en) begin
                if (st.half == '0) begin
                    // Stopped: held low; a pending value restarts counting from zero.
                    st.counter <= '0;
                    st.out     <= 1'b0;
                    if (st.pend) begin
                        st.half <= st.shadow;
                        st.pend <= 1'b0;
                    end
                end else if (at_end) begin
                    st.counter <= '0;
                    // Switching to a zero half parks the output low straight away.
                    st.out     <= (st.pend && (st.shadow == '0)) ? 1'b0 : ~st.out;
                    if (st.pend) begin
                        st.half <= st.shadow;
                        st.pend <= 1'b0;
                    end
                end else begin
                    st.counter <= st.counter + CNT_W'(1);
                end
            end
            if (wr) begin
                st.shadow <= wr_val;
                st.pend   <= 1'b1;
            end
        end
    end

    assign pend    = st.pend;
    assign clk_out = st.out;

`ifdef CLKDIV_TICK_EN
    logic tick_q;

    // One-cycle pulse registered alongside each toggle; suppressed while frozen or cleared.
    always_ff @(posedge clk_in) begin
        if (!rst_n || sync_clr || !en) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= at_end;
        end
    end

    assign tick = tick_q;
`else
    assign tick = 1'b0;
`endif

endmodule

// File: rtl/clkdiv_multi.sv
// NUM_CH-channel programmable clock divider producing slow square waves and toggle ticks (tick needs CLKDIV_TICK_EN).
// Latency: div_wr lands in the shadow next edge; it takes effect at that channel's next toggle or on sync_clr.
// Backpressure: none; writes are always accepted, writes with div_sel >= NUM_CH are dropped.
module clkdiv_multi
    import clkdiv_pkg::*;
#(
    parameter int  NUM_CH        = 2,
    parameter int  CNT_W         = CNT_W_DEF,
    parameter int  DIV_INIT0     = HALF_2HZ,
    parameter int  DIV_INIT1     = HALF_10S,
    parameter int  DIV_INIT_REST = HALF_1HZ,
    localparam int SEL_W         = sel_width(NUM_CH)
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              en,
    input  logic              sync_clr,
    input  logic              div_wr,
    input  logic [SEL_W-1:0]  div_sel,
    input  logic [CNT_W-1:0]  div_val,
    output logic [NUM_CH-1:0] div_pend,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam int INIT = (i == 0) ? DIV_INIT0 :
                              (i == 1) ? DIV_INIT1 : DIV_INIT_REST;

        // Select decode; an out-of-range div_sel matches no channel.
        logic wr_ch;
        assign wr_ch = div_wr && (div_sel == SEL_W'(i));

        clkdiv_channel #(
            .CNT_W    (CNT_W),
            .DIV_INIT (CNT_W'(INIT))
        ) u_ch (
            .clk_in   (clk_in),
            .rst_n    (rst_n),
            .en       (en),
            .sync_clr (sync_clr),
            .wr       (wr_ch),
            .wr_val   (div_val),
            .pend     (div_pend[i]),
            .clk_out  (clk_out[i]),
            .tick     (tick[i])
        );
    end

endmodule

// File: tb/tb_clkdiv_multi.sv
module tb_clkdiv_multi;

    localparam int NUM_CH = 3;
    localparam int CNT_W  = 8;

    logic              clk_in   = 1'b0;
    logic              rst_n    = 1'b0;
    logic              en       = 1'b0;
    logic              sync_clr = 1'b0;
    logic              div_wr   = 1'b0;
    logic [1:0]        div_sel  = '0;
    logic [CNT_W-1:0]  div_val  = '0;
    logic [NUM_CH-1:0] div_pend;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;

    int cyc    = 0;
    int n_chk  = 0;
    int n_pass = 0;

    // Expected observation of one channel after edge number 'at'; -1 means don't care.
    typedef struct {
        int    at;
        int    ch;
        int    e_clk;
        int    e_tick;
        int    e_pend;
        string name;
    } exp_t;

    exp_t q[$];

    clkdiv_multi #(
        .NUM_CH        (NUM_CH),
        .CNT_W         (CNT_W),
        .DIV_INIT0     (3),
        .DIV_INIT1     (5),
        .DIV_INIT_REST (2)
    ) dut (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .en       (en),
        .sync_clr (sync_clr),
        .div_wr   (div_wr),
        .div_sel  (div_sel),
        .div_val  (div_val),
        .div_pend (div_pend),
        .clk_out  (clk_out),
        .tick     (tick)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    // Queue an expectation, kept sorted by cycle.
    task automatic ex(input int at, input int ch, input int c, input int t, input int p, input string name);
        exp_t e;
        int   idx;
`ifndef CLKDIV_TICK_EN
        if (t >= 0) t = 0;
`endif
        e.at = at; e.ch = ch; e.e_clk = c; e.e_tick = t; e.e_pend = p; e.name = name;
        idx = q.size();
        for (int i = 0; i < q.size(); i++) begin
            if (q[i].at > at) begin
                idx = i;
                break;
            end
        end
        q.insert(idx, e);
    endtask

    task automatic cmp(input string name, input int ch, input string what, input logic act, input int exp_v);
        n_chk++;
        if (act === 1'(exp_v)) n_pass++;
        else $display("FAIL %s ch%0d %s at cycle %0d: got %b, expected %0d", name, ch, what, cyc, act, exp_v);
    endtask

    // Monitor: outputs are presented every cycle; compare whatever is due this cycle.
    always @(negedge clk_in) begin : mon
        exp_t e;
        while (q.size() > 0 && q[0].at <= cyc) begin
            e = q.pop_front();
            if (e.at < cyc) begin
                n_chk++;
                $display("FAIL %s ch%0d: check for cycle %0d missed (now %0d)", e.name, e.ch, e.at, cyc);
            end else begin
                if (e.e_clk  >= 0) cmp(e.name, e.ch, "clk_out",  clk_out[e.ch],  e.e_clk);
                if (e.e_tick >= 0) cmp(e.name, e.ch, "tick",     tick[e.ch],     e.e_tick);
                if (e.e_pend >= 0) cmp(e.name, e.ch, "div_pend", div_pend[e.ch], e.e_pend);
            end
        end
    end

    // Advance to 1 time unit after edge number c.
    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic wr(input int sel, input int val);
        div_wr  = 1'b1;
        div_sel = 2'(sel);
        div_val = CNT_W'(val);
    endtask

    initial begin
        // Reset and first periods: halves 3/5/2, counting starts after edge 3.
        for (int ch = 0; ch < NUM_CH; ch++) ex(3, ch, 0, 0, 0, "reset");
        ex(4, 0, 0, 0, 0, "ch0_cnt1");   ex(5, 0, 0, 0, -1, "ch0_cnt2");
        ex(6, 0, 1, 1, 0, "ch0_rise");   ex(7, 0, 1, 0, -1, "ch0_high");
        ex(9, 0, 0, 1, -1, "ch0_fall");  ex(12, 0, 1, 1, -1, "ch0_rise2");
        ex(7, 1, 0, 0, -1, "ch1_low");   ex(8, 1, 1, 1, 0, "ch1_rise");
        ex(13, 1, 0, 1, -1, "ch1_fall");
        ex(5, 2, 1, 1, -1, "ch2_rise");  ex(6, 2, 1, 0, -1, "ch2_high");
        ex(7, 2, 0, 1, -1, "ch2_fall");
        goto(3);
        rst_n = 1'b1;
        en    = 1'b1;

        // Write 5 to ch0 mid-half; applies at the fall on edge 15.
        ex(14, 0, 1, -1, 1, "wr5_pend"); ex(15, 0, 0, 1, 0, "apply5");
        ex(19, 0, 0, 0, -1, "h5_low");   ex(20, 0, 1, 1, -1, "h5_rise");
        ex(24, 0, 1, -1, -1, "h5_high"); ex(25, 0, 0, 1, -1, "h5_fall");
        goto(13); wr(0, 5);
        goto(14); div_wr = 1'b0;

        // Half 1, then half 0 written on a toggle edge, then restart with 4.
        ex(26, 0, -1, -1, 1, "wr1_pend"); ex(30, 0, 1, 1, 0, "apply1");
        ex(31, 0, 0, 1, -1, "h1_a");      ex(32, 0, 1, 1, -1, "h1_b");
        ex(33, 0, 0, 1, -1, "h1_c");      ex(34, 0, 1, 1, 1, "wr0_on_toggle");
        ex(35, 0, 0, -1, 0, "apply0");    ex(36, 0, 0, 0, 0, "stopped");
        ex(39, 0, 0, 0, 0, "stopped2");   ex(40, 0, 0, 0, 1, "wr4_stopped");
        ex(41, 0, 0, 0, 0, "restart");    ex(44, 0, 0, 0, -1, "restart_low");
        ex(45, 0, 1, 1, -1, "restart_rise"); ex(49, 0, 0, 1, -1, "restart_fall");
        goto(25); wr(0, 1);
        goto(26); div_wr = 1'b0;
        goto(33); wr(0, 0);
        goto(34); div_wr = 1'b0;
        goto(39); wr(0, 4);
        goto(40); div_wr = 1'b0;

        // ch0 gets 3 pending, then sync_clr together with a write to ch2.
        ex(54, 0, 1, -1, 1, "wr3_pend");
        ex(56, 0, 0, 0, 0, "clr_ch0");   ex(56, 1, 0, 0, 0, "clr_ch1");
        ex(56, 2, 0, 0, 1, "clr_wr_kept");
        ex(58, 0, 0, 0, -1, "clr_ch0_low"); ex(58, 1, 0, 0, -1, "clr_ch1_low");
        ex(58, 2, 1, 1, 0, "ch2_apply4");
        ex(59, 0, 1, 1, -1, "realign_ch0"); ex(60, 1, 0, 0, -1, "ch1_wait");
        ex(61, 1, 1, 1, -1, "realign_ch1"); ex(61, 2, 1, 0, -1, "ch2_h4_hold");
        ex(62, 0, 0, 1, -1, "ch0_h3_fall"); ex(62, 2, 0, 1, -1, "ch2_h4_fall");
        goto(53); wr(0, 3);
        goto(54); div_wr = 1'b0;
        goto(55); sync_clr = 1'b1; wr(2, 4);
        goto(56); sync_clr = 1'b0; div_wr = 1'b0;

        // en low for edges 64..70; a write to ch2 is still accepted.
        ex(64, 0, 0, 0, -1, "frz_a");       ex(65, 2, 0, -1, 1, "frz_wr_pend");
        ex(66, 2, 0, 0, 1, "frz_no_tick");  ex(66, 1, 1, 0, 0, "frz_ch1");
        ex(70, 0, 0, 0, -1, "frz_end");     ex(70, 1, 1, 0, -1, "frz_end_ch1");
        ex(71, 0, 0, 0, -1, "resume");      ex(72, 0, 1, 1, -1, "resume_rise");
        ex(72, 1, 1, 0, -1, "resume_ch1");  ex(73, 1, 0, 1, -1, "resume_ch1_fall");
        ex(73, 2, 1, 1, 0, "resume_apply2"); ex(75, 2, 0, 1, -1, "ch2_h2");
        goto(63); en = 1'b0;
        goto(64); wr(2, 2);
        goto(65); div_wr = 1'b0;
        goto(70); en = 1'b1;

        // Reset mid-count with ch1 write pending; released after edge 82.
        ex(79, 1, 1, -1, 1, "wr9_pend");
        for (int ch = 0; ch < NUM_CH; ch++) ex(81, ch, 0, 0, 0, "midrst");
        ex(84, 2, 1, 1, 0, "rst_ch2_init");  ex(85, 0, 1, 1, 0, "rst_ch0_init");
        ex(86, 1, 0, 0, -1, "rst_ch1_low");  ex(87, 1, 1, 1, 0, "rst_ch1_init");
        goto(78); wr(1, 9);
        goto(79); div_wr = 1'b0;
        goto(80); rst_n = 1'b0;
        goto(82); rst_n = 1'b1;

        // Out-of-range select, then back-to-back writes 7 and 9 to ch0.
        for (int ch = 0; ch < NUM_CH; ch++) ex(88, ch, -1, -1, 0, "oor_nopend");
        ex(88, 0, 0, 1, -1, "oor_ch0");      ex(88, 2, 1, 1, -1, "oor_ch2");
        ex(91, 0, 1, 1, -1, "oor_ch0_h3");   ex(92, 1, 0, 1, -1, "oor_ch1_h5");
        ex(95, 0, 0, -1, 1, "b2b_pend7");    ex(96, 0, 0, -1, 1, "b2b_pend9");
        ex(97, 0, 1, 1, 0, "b2b_apply");     ex(105, 0, 1, 0, -1, "b2b_hold9");
        ex(106, 0, 0, 1, -1, "b2b_fall9");   ex(115, 0, 1, 1, -1, "b2b_rise9");
        goto(87); wr(3, 1);
        goto(88); div_wr = 1'b0;
        goto(94); wr(0, 7);
        goto(95); wr(0, 9);
        goto(96); div_wr = 1'b0;

        goto(118);
        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk_in);
        while (q.size() > 0) begin
            n_chk++;
            $display("FAIL %s ch%0d: expectation for cycle %0d never checked", q[0].name, q[0].ch, q[0].at);
            void'(q.pop_front());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
